// File: rtl/aes128_ecb_dec_iter_if.sv
// AXI-Stream bundle shared by the AES ECB blocks.
// Carries tdata, tkeep, tvalid, tready and tlast.
// WIDTH is the tdata width in bits and must be a multiple of 8.
interface axis_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0]   tdata;
  logic [WIDTH/8-1:0] tkeep;
  logic               tvalid;
  logic               tready;
  logic               tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/aes128_ecb_dec_iter.sv
// Iterative AES-128 ECB decryptor with AXI-Stream framing.
// Each packet carries one key followed by one or more ciphertext blocks.
// The key is expanded once into a local round-key store.
// Each block then takes one inverse round per cycle and is returned as plaintext.
// Ports:
//   Clk    - rising-edge clock
//   Rst    - synchronous active-high reset
//   S_axis - key then ciphertext beats; tkeep is ignored
//   M_axis - plaintext beats; tlast is set on the final beat of the packet
// Byte 0 of every 128-bit word travels in tdata[7:0] of the first beat.

package aes128_ecb_dec_iter_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse in GF(2^8) computed as x^254; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = gf_mul(x, x);
    for (int i = 1; i < 8; i++) begin
      r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// Row r of the state is rotated right by r columns; state byte 4c+r is row r of column c.
module aes_inv_shift_rows (
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign state_o[8*(4*c+r) +: 8] = state_i[8*(4*((c-r+4)%4)+r) +: 8];
    end
  end
endmodule

// Inverse S-box applied to each of the 16 bytes.
module aes_inv_sub_bytes
  import aes128_ecb_dec_iter_pkg::*;
(
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign state_o[8*i +: 8] = inv_sbox(state_i[8*i +: 8]);
  end
endmodule

// Inverse MixColumns applied to each 32-bit column.
module aes_inv_mix_columns
  import aes128_ecb_dec_iter_pkg::*;
(
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a3, a2, a1, a0} = state_i[32*c +: 32];
    assign state_o[32*c +: 8]    = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign state_o[32*c+8 +: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign state_o[32*c+16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign state_o[32*c+24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end
endmodule

module aes_add_round_key (
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  output logic [127:0] state_o
);
  assign state_o = state_i ^ key_i;
endmodule

// One step of the AES-128 schedule: derives rk[round_i] from rk[round_i-1].
module aes128_key_expansion_port
  import aes128_ecb_dec_iter_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [3:0]   round_i,
  output logic [127:0] key_o
);
  logic [31:0] w0, w1, w2, w3, rot, tmp, n0, n1, n2, n3;
  assign {w3, w2, w1, w0} = key_i;
  // RotWord moves byte 1 of w3 into byte 0.
  assign rot = {w3[7:0], w3[31:8]};
  assign tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0]) ^ rcon(round_i)};
  assign n0 = w0 ^ tmp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign key_o = {n3, n2, n1, n0};
endmodule

module aes128_ecb_dec_iter #(
  parameter int unsigned S_AXIS_WIDTH = 32,
  parameter int unsigned M_AXIS_WIDTH = 32
) (
  input logic   Clk,
  input logic   Rst,
  axis_if.slave  S_axis,
  axis_if.master M_axis
);
  localparam int unsigned IN_BEATS  = 128 / S_AXIS_WIDTH;
  localparam int unsigned OUT_BEATS = 128 / M_AXIS_WIDTH;
  localparam int unsigned KEEP_W    = M_AXIS_WIDTH / 8;
  localparam int unsigned CNT_W     = 2;
  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_BEATS - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_BEATS - 1);

  typedef enum logic [6:0] {
    ST_KEY_IN       = 7'b000_0001,
    ST_KEY_EXPAND   = 7'b000_0010,
    ST_CT_IN        = 7'b000_0100,
    ST_ZERO_ROUND   = 7'b000_1000,
    ST_MIDDLE_ROUND = 7'b001_0000,
    ST_FINAL_ROUND  = 7'b010_0000,
    ST_PT_OUT       = 7'b100_0000
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    in_cnt_q, out_cnt_q;
  logic [3:0]          rnd_q;
  logic [127:0]        st_q;
  logic [127:0]        rk_q [11];
  logic                tlast_reg_q;
  logic                s_tready_q, m_tvalid_q, m_tlast_q;
  logic [KEEP_W-1:0]   m_tkeep_q;
  logic [M_AXIS_WIDTH-1:0] m_tdata_q;

  logic [127:0] shift_in, shift_out, rk_cur, kexp_src, kexp;
  logic [127:0] isr, isb, ark_in, ark, imc;
  logic         s_hs, m_hs;

  assign s_hs = s_tready_q & S_axis.tvalid;
  assign m_hs = m_tvalid_q & M_axis.tready;

  // New beats enter at the top so the first beat ends up least significant.
  if (S_AXIS_WIDTH == 128) begin : g_in_full
    assign shift_in = S_axis.tdata;
  end else begin : g_in_part
    assign shift_in = {S_axis.tdata, st_q[127:S_AXIS_WIDTH]};
  end

  if (M_AXIS_WIDTH == 128) begin : g_out_full
    assign shift_out = '0;
  end else begin : g_out_part
    assign shift_out = {{M_AXIS_WIDTH{1'b0}}, st_q[127:M_AXIS_WIDTH]};
  end

  // rk_cur feeds the decrypt rounds; kexp_src is the previous key for expansion.
  always_comb begin
    rk_cur   = '0;
    kexp_src = '0;
    for (int i = 0; i < 11; i++) begin
      if (rnd_q == 4'(i))     rk_cur   = rk_q[i];
      if (rnd_q == 4'(i + 1)) kexp_src = rk_q[i];
    end
  end

  aes128_key_expansion_port u_kexp (.key_i(kexp_src), .round_i(rnd_q), .key_o(kexp));
  aes_inv_shift_rows        u_isr  (.state_i(st_q), .state_o(isr));
  aes_inv_sub_bytes         u_isb  (.state_i(isr), .state_o(isb));
  // The initial round only whitens the ciphertext with rk[10].
  assign ark_in = (state_q == ST_ZERO_ROUND) ? st_q : isb;
  aes_add_round_key         u_ark  (.state_i(ark_in), .key_i(rk_cur), .state_o(ark));
  aes_inv_mix_columns       u_imc  (.state_i(ark), .state_o(imc));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_KEY_IN;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      rnd_q       <= '0;
      st_q        <= '0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
      tlast_reg_q <= 1'b0;
      s_tready_q  <= 1'b1;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tkeep_q   <= '0;
      m_tdata_q   <= '0;
    end else begin
      case (state_q)
        ST_KEY_IN: begin
          if (s_hs) begin
            st_q <= shift_in;
            if (in_cnt_q == IN_LAST) begin
              in_cnt_q   <= '0;
              rk_q[0]    <= shift_in;
              rnd_q      <= 4'd1;
              s_tready_q <= 1'b0;
              state_q    <= ST_KEY_EXPAND;
            end else begin
              in_cnt_q <= in_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_KEY_EXPAND: begin
          for (int i = 1; i < 11; i++) begin
            if (rnd_q == 4'(i)) rk_q[i] <= kexp;
          end
          if (rnd_q == 4'd10) begin
            rnd_q      <= '0;
            s_tready_q <= 1'b1;
            state_q    <= ST_CT_IN;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        ST_CT_IN: begin
          if (s_hs) begin
            st_q <= shift_in;
            if (in_cnt_q == IN_LAST) begin
              in_cnt_q    <= '0;
              tlast_reg_q <= S_axis.tlast;
              rnd_q       <= 4'd10;
              s_tready_q  <= 1'b0;
              state_q     <= ST_ZERO_ROUND;
            end else begin
              in_cnt_q <= in_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_ZERO_ROUND: begin
          st_q    <= ark;
          rnd_q   <= 4'd9;
          state_q <= ST_MIDDLE_ROUND;
        end
        ST_MIDDLE_ROUND: begin
          st_q <= imc;
          if (rnd_q == 4'd1) begin
            rnd_q   <= '0;
            state_q <= ST_FINAL_ROUND;
          end else begin
            rnd_q <= rnd_q - 4'd1;
          end
        end
        ST_FINAL_ROUND: begin
          st_q       <= ark;
          m_tvalid_q <= 1'b1;
          m_tkeep_q  <= '1;
          m_tdata_q  <= M_AXIS_WIDTH'(ark);
          m_tlast_q  <= (OUT_LAST == '0) ? tlast_reg_q : 1'b0;
          out_cnt_q  <= OUT_LAST;
          state_q    <= ST_PT_OUT;
        end
        ST_PT_OUT: begin
          if (m_hs) begin
            if (out_cnt_q == '0) begin
              m_tvalid_q <= 1'b0;
              m_tlast_q  <= 1'b0;
              m_tkeep_q  <= '0;
              m_tdata_q  <= '0;
              s_tready_q <= 1'b1;
              state_q    <= tlast_reg_q ? ST_KEY_IN : ST_CT_IN;
            end else begin
              st_q      <= shift_out;
              m_tdata_q <= M_AXIS_WIDTH'(shift_out);
              m_tlast_q <= (out_cnt_q == CNT_W'(1)) ? tlast_reg_q : 1'b0;
              out_cnt_q <= out_cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          state_q    <= ST_KEY_IN;
          in_cnt_q   <= '0;
          out_cnt_q  <= '0;
          rnd_q      <= '0;
          s_tready_q <= 1'b1;
          m_tvalid_q <= 1'b0;
          m_tlast_q  <= 1'b0;
          m_tkeep_q  <= '0;
          m_tdata_q  <= '0;
        end
      endcase
    end
  end

  assign S_axis.tready = s_tready_q;
  assign M_axis.tvalid = m_tvalid_q;
  assign M_axis.tlast  = m_tlast_q;
  assign M_axis.tkeep  = m_tkeep_q;
  assign M_axis.tdata  = m_tdata_q;
endmodule

// File: doc/aes128_ecb_dec_iter.md
Name: aes128_ecb_dec_iter

Overview:
Iterative AES-128 ECB decryptor; the receive-side counterpart of the team's iterative AES-128 ECB encryptor, using the same AXI-Stream framing.
Per packet it accepts one 128-bit key, then one or more 128-bit ciphertext blocks, and returns one plaintext block per input block.
Round keys are expanded once per key into a local key store and then applied in reverse order.
The datapath performs one inverse round per cycle, built from combinational aes_inv_shift_rows, aes_inv_sub_bytes, aes_inv_mix_columns, aes_add_round_key and aes128_key_expansion_port.

Parameters:
S_AXIS_WIDTH, 32, input beat width in bits; must divide 128; legal values 32, 64, 128.
M_AXIS_WIDTH, 32, output beat width in bits; must divide 128; legal values 32, 64, 128.

Ports:
Clk  input  1  clock, rising edge.
Rst  input  1  reset; synchronous, active-high.
S_axis  axis_if.slave  S_AXIS_WIDTH  key then ciphertext stream.
- Uses tdata, tvalid, tready, tlast.
- Input tkeep is ignored; all bytes are treated as valid.
M_axis  axis_if.master  M_AXIS_WIDTH  plaintext stream.
- Drives tdata, tvalid, tlast, tkeep; samples tready.

Behaviour:
- Beats and words: IN = 128/S_AXIS_WIDTH beats per key or block; OUT = 128/M_AXIS_WIDTH beats per block.
- Byte order: first beat carries the least-significant word.
  - FIPS-197 byte 0 sits in tdata[7:0] of the first beat.
  - This applies identically to key, ciphertext and plaintext.
- States (one-hot): KEY_IN, KEY_EXPAND, CT_IN, ZERO_ROUND, MIDDLE_ROUND, FINAL_ROUND, PT_OUT.
- Reset: state=KEY_IN, all counters cleared, key store and data registers zeroed.
- Output values in reset and in every non-PT_OUT state:
  - S_axis.tready=1 in KEY_IN and CT_IN, else 0.
  - M_axis.tvalid=0, tlast=0, tkeep=0, tdata=0.
- KEY_IN:
  - Shift in IN beats; each beat enters at the top and the register shifts right.
  - Input tlast is ignored here.
  - On the last accepted beat: go to KEY_EXPAND; rk[0]=key.
- KEY_EXPAND: 10 cycles, round counter r=1..10.
  - Each cycle: rk[r] = expand(rk[r-1], r).
  - tready=0 throughout.
  - After r=10: go to CT_IN.
- CT_IN:
  - Shift in IN beats of ciphertext.
  - Latch S_axis.tlast of the last beat into tlast_reg.
  - On the last accepted beat: go to ZERO_ROUND.
- ZERO_ROUND (1 cycle): state = ct XOR rk[10].
- MIDDLE_ROUND: 9 cycles, r=9 down to 1.
  - Each cycle: state = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[r])).
  - After r=1: go to FINAL_ROUND.
- FINAL_ROUND (1 cycle): state = AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[0]).
- PT_OUT:
  - tvalid=1, tkeep all ones, tdata = low M_AXIS_WIDTH bits of the result register.
  - The register shifts right by M_AXIS_WIDTH only on a handshake (tvalid&tready).
  - The beat counter decrements only on a handshake.
  - When tready is low, tdata and tlast hold stable.
  - tlast = tlast_reg on the final beat of the block, else 0.
  - After the final-beat handshake: go to KEY_IN if tlast_reg=1, else CT_IN.
  - The key store is retained across blocks of the same packet.
- Latency: last ciphertext beat accepted at edge N → ZERO_ROUND in cycle N+1 → first tvalid in cycle N+12.
- Key expansion: the first ciphertext beat is accepted no earlier than 11 cycles after the last key beat.
- Throughput: ECB blocks are fully serialized, with no overlap of input, rounds and output.
- Rst asserted in any state, including mid-expansion, mid-round or mid-output:
  - Next cycle the block is in KEY_IN with outputs at reset values.
  - Any partial key or block is discarded.
- Illegal one-hot state encoding: recover to KEY_IN.

Test Plan:
- FIPS-197 C.1, S/M width 32:
  - Stimulus: key beats 03020100, 07060504, 0b0a0908, 0f0e0d0c; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a (first beat d8e0c469), tlast on beat 4.
  - Required: plaintext beats 33221100, 77665544, bbaa9988, ffeeddcc; tlast on beat 4 only; first tvalid 12 cycles after the last ct beat.
- SP800-38A ECB-AES128, two blocks in one packet:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c; ct 3ad77bb40d7a3660a89ecaf32466ef97 then f5d3d58503b9699de785895a96fdbaaf; tlast on block 2 only.
  - Required: pt 6bc1bee22e409f96e93d7e117393172a then ae2d8a571e03ac9c9eb76fac45af8e51; tlast asserted only on the final beat of block 2.
- New key per packet: C.1 packet followed by SP800-38A packet → both plaintexts correct, proving rk is reloaded after tlast.
- Backpressure: M tready=0 for 5 cycles mid-block, then alternating 1/0 → tdata/tlast stable while stalled; exactly 4 beats, no beat dropped or duplicated.
- Reset mid-operation: Rst pulsed during KEY_EXPAND and again during MIDDLE_ROUND → outputs return to reset values the next cycle; the following complete C.1 packet decrypts correctly.
- Width 128/128 parametrization: C.1 vector as single beats → one output beat 0xffeeddccbbaa99887766554433221100 with tlast=1.
